// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared widths and MEM/WB field layout for pipe_stage_reg users
package pipe_pkg;

  localparam int PIPE_CTRL_W = 2;
  localparam int PIPE_DATA_W = 36;

  localparam int WB_DST_W    = 4;
  localparam int MEM_DATA_W  = 16;
  localparam int ALU_RES_W   = 16;

  localparam int ALU_RES_LSB  = 0;
  localparam int MEM_DATA_LSB = ALU_RES_LSB + ALU_RES_W;
  localparam int WB_DST_LSB   = MEM_DATA_LSB + MEM_DATA_W;

  localparam int CTRL_REG_WRT    = 0;
  localparam int CTRL_MEM_TO_REG = 1;

  typedef struct packed {
    logic [WB_DST_W-1:0]   wb_dst;
    logic [MEM_DATA_W-1:0] mem_data;
    logic [ALU_RES_W-1:0]  alu_result;
  } mem_wb_data_t;

  typedef struct packed {
    logic mem_to_reg;
    logic reg_wrt;
  } mem_wb_ctrl_t;

  function automatic logic [PIPE_DATA_W-1:0] pack_mem_wb(
    input logic [WB_DST_W-1:0]   wb_dst,
    input logic [MEM_DATA_W-1:0] mem_data,
    input logic [ALU_RES_W-1:0]  alu_result
  );
    mem_wb_data_t d;
    d.wb_dst     = wb_dst;
    d.mem_data   = mem_data;
    d.alu_result = alu_result;
    return d;
  endfunction

endpackage

// File: rtl/pipe_entry.sv
// rtl/pipe_entry.sv - one valid+ctrl+data pipeline register slot
module pipe_entry
  import pipe_pkg::*;
#(
  parameter int CTRL_W   = PIPE_CTRL_W,
  parameter int DATA_W   = PIPE_DATA_W,
  parameter bit DATA_RST = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              load,
  input  logic              unload,
  input  logic [CTRL_W-1:0] d_ctrl,
  input  logic [DATA_W-1:0] d_data,
  output logic              valid,
  output logic [CTRL_W-1:0] ctrl,
  output logic [DATA_W-1:0] data
);

  logic              valid_q;
  logic [CTRL_W-1:0] ctrl_q;
  logic [DATA_W-1:0] data_q;

  // load wins over unload so a same-edge replace keeps the slot occupied
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      valid_q <= 1'b0;
      ctrl_q  <= '0;
    end else if (load) begin
      valid_q <= 1'b1;
      ctrl_q  <= d_ctrl;
    end else if (unload) begin
      valid_q <= 1'b0;
      ctrl_q  <= '0;
    end
  end

  // payload is never cleared by flush, but a beat arriving in the flush cycle must not land
  generate
    if (DATA_RST) begin : g_data_rst
      always_ff @(posedge clk) begin
        if (rst) begin
          data_q <= '0;
        end else if (load && !clear) begin
          data_q <= d_data;
        end
      end
    end else begin : g_data_norst
      always_ff @(posedge clk) begin
        if (load && !clear) begin
          data_q <= d_data;
        end
      end
    end
  endgenerate

  assign valid = valid_q;
  assign ctrl  = valid_q ? ctrl_q : '0;
  assign data  = data_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// rtl/pipe_stage_reg.sv - valid/ready inter-stage register, optional skid entry via PIPE_SKID_EN
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int CTRL_W   = PIPE_CTRL_W,
  parameter int DATA_W   = PIPE_DATA_W,
  parameter bit DATA_RST = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_clear,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [CTRL_W-1:0] i_ctrl,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [CTRL_W-1:0] o_ctrl,
  output logic [DATA_W-1:0] o_data,
  output logic [1:0]        o_count
);

  logic              accept;
  logic              deliver;
  logic              head_load;
  logic              head_unload;
  logic              head_valid;
  logic [CTRL_W-1:0] head_ctrl;
  logic [DATA_W-1:0] head_data;
  logic [CTRL_W-1:0] head_d_ctrl;
  logic [DATA_W-1:0] head_d_data;

  assign accept  = i_valid && o_ready;
  assign deliver = head_valid && i_ready;

`ifdef PIPE_SKID_EN

  logic              skid_load;
  logic              skid_unload;
  logic              skid_valid;
  logic              skid_valid_nxt;
  logic [CTRL_W-1:0] skid_ctrl;
  logic [DATA_W-1:0] skid_data;
  logic              ready_q;

  // head refills from skid first; skid is only written when head stalls
  assign head_load   = (skid_valid && deliver) || (accept && (!head_valid || deliver));
  assign head_unload = deliver && !head_load;
  assign head_d_ctrl = skid_valid ? skid_ctrl : i_ctrl;
  assign head_d_data = skid_valid ? skid_data : i_data;

  assign skid_load      = accept && head_valid && !deliver;
  assign skid_unload    = skid_valid && deliver;
  assign skid_valid_nxt = skid_load || (skid_valid && !skid_unload);

  always_ff @(posedge clk) begin
    if (rst) begin
      ready_q <= 1'b0;
    end else if (i_clear) begin
      ready_q <= 1'b1;
    end else begin
      ready_q <= !skid_valid_nxt;
    end
  end

  pipe_entry #(
    .CTRL_W   (CTRL_W),
    .DATA_W   (DATA_W),
    .DATA_RST (DATA_RST)
  ) u_skid (
    .clk    (clk),
    .rst    (rst),
    .clear  (i_clear),
    .load   (skid_load),
    .unload (skid_unload),
    .d_ctrl (i_ctrl),
    .d_data (i_data),
    .valid  (skid_valid),
    .ctrl   (skid_ctrl),
    .data   (skid_data)
  );

  assign o_ready = ready_q;
  assign o_count = {1'b0, head_valid} + {1'b0, skid_valid};

`else

  logic ready_en;

  // holds o_ready low until the first edge after reset releases
  always_ff @(posedge clk) begin
    if (rst) begin
      ready_en <= 1'b0;
    end else begin
      ready_en <= 1'b1;
    end
  end

  assign head_load   = accept;
  assign head_unload = deliver;
  assign head_d_ctrl = i_ctrl;
  assign head_d_data = i_data;

  assign o_ready = ready_en && (!head_valid || i_ready);
  assign o_count = {1'b0, head_valid};

`endif

  pipe_entry #(
    .CTRL_W   (CTRL_W),
    .DATA_W   (DATA_W),
    .DATA_RST (DATA_RST)
  ) u_head (
    .clk    (clk),
    .rst    (rst),
    .clear  (i_clear),
    .load   (head_load),
    .unload (head_unload),
    .d_ctrl (head_d_ctrl),
    .d_data (head_d_data),
    .valid  (head_valid),
    .ctrl   (head_ctrl),
    .data   (head_data)
  );

  assign o_valid = head_valid;
  assign o_ctrl  = head_ctrl;
  assign o_data  = head_data;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb/tb_pipe_stage_reg.sv - directed-vector bench for pipe_stage_reg (either PIPE_SKID_EN setting)
module tb_pipe_stage_reg;

  localparam int CW = 2;
  localparam int DW = 36;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_clear;
  logic          i_valid;
  logic          o_ready;
  logic [CW-1:0] i_ctrl;
  logic [DW-1:0] i_data;
  logic          o_valid;
  logic          i_ready;
  logic [CW-1:0] o_ctrl;
  logic [DW-1:0] o_data;
  logic [1:0]    o_count;

  int n_vec = 0;
  int n_bad = 0;

  pipe_stage_reg #(
    .CTRL_W   (CW),
    .DATA_W   (DW),
    .DATA_RST (1'b1)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .i_clear (i_clear),
    .i_valid (i_valid),
    .o_ready (o_ready),
    .i_ctrl  (i_ctrl),
    .i_data  (i_data),
    .o_valid (o_valid),
    .i_ready (i_ready),
    .o_ctrl  (o_ctrl),
    .o_data  (o_data),
    .o_count (o_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=0x%0h exp=0x%0h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // upstream must hold a stalled beat unchanged until it is taken
  logic          stall_q = 1'b0;
  logic [CW+DW:0] held_q;
  always @(posedge clk) begin
    if (stall_q) chk("in_stable", {63'd0, i_valid, i_ctrl, i_data}, {63'd0, held_q});
    stall_q <= i_valid && !o_ready && !rst && !i_clear;
    held_q  <= {i_valid, i_ctrl, i_data};
  end

  initial begin
    rst = 1'b1; i_clear = 1'b0; i_valid = 1'b0; i_ready = 1'b0;
    i_ctrl = '0; i_data = '0;
    tick(); tick();
    #2;
    chk("rst_valid", o_valid, 0);
    chk("rst_ctrl",  o_ctrl,  0);
    chk("rst_count", o_count, 0);
    chk("rst_data",  o_data,  0);
    rst = 1'b0;
    tick();
    chk("rst_ready", o_ready, 1);

    // streaming, full throughput
    i_ready = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      i_valid = 1'b1; i_ctrl = 2'b11; i_data = DW'(k);
      tick();
      chk($sformatf("str_valid%0d", k), o_valid, 1);
      chk($sformatf("str_data%0d", k),  o_data,  k);
      chk($sformatf("str_ctrl%0d", k),  o_ctrl,  2'b11);
      chk($sformatf("str_ready%0d", k), o_ready, 1);
    end
    i_valid = 1'b0;
    tick();
    chk("str_drain_valid", o_valid, 0);
    chk("str_drain_count", o_count, 0);

    // bubble gating: ctrl driven but nothing valid
    i_ctrl = 2'b11; i_data = 36'h77;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("bub_valid", o_valid, 0);
      chk("bub_ctrl",  o_ctrl,  0);
    end

    // backpressure
    i_ready = 1'b0;
    i_valid = 1'b1; i_ctrl = 2'b01; i_data = 36'hA;
    #1;
    chk("bp_ready_empty", o_ready, 1);
    tick();
    i_ctrl = 2'b10; i_data = 36'hB;
    #1;
    chk("bp_head_data", o_data, 36'hA);
`ifdef PIPE_SKID_EN
    chk("bp_ready_skidfree", o_ready, 1);
    tick();
    i_valid = 1'b0;
    #1;
    chk("bp_count2", o_count, 2);
    chk("bp_ready_full", o_ready, 0);
    chk("bp_head_hold", o_data, 36'hA);
    chk("bp_head_ctrl", o_ctrl, 2'b01);
    i_ready = 1'b1;
    tick();
    chk("bp_out_b", o_data, 36'hB);
    chk("bp_out_b_ctrl", o_ctrl, 2'b10);
    chk("bp_count1", o_count, 1);
    chk("bp_ready_back", o_ready, 1);
    tick();
    chk("bp_empty_valid", o_valid, 0);
    chk("bp_empty_count", o_count, 0);
`else
    chk("bp_ready_same", o_ready, 0);
    chk("bp_count1", o_count, 1);
    tick(); tick();
    chk("bp_head_hold", o_data, 36'hA);
    chk("bp_head_ctrl", o_ctrl, 2'b01);
    chk("bp_ready_hold", o_ready, 0);
    i_ready = 1'b1;
    #1;
    chk("bp_ready_comb", o_ready, 1);
    tick();
    i_valid = 1'b0;
    chk("bp_out_b", o_data, 36'hB);
    chk("bp_out_b_ctrl", o_ctrl, 2'b10);
    chk("bp_out_b_count", o_count, 1);
    tick();
    chk("bp_empty_valid", o_valid, 0);
    chk("bp_empty_count", o_count, 0);
`endif

    // flush with a beat offered in the same cycle
    i_ready = 1'b0; i_valid = 1'b1; i_ctrl = 2'b01; i_data = 36'h33;
    tick();
    chk("fl_pre_count", o_count, 1);
    i_ready = 1'b1; i_clear = 1'b1; i_ctrl = 2'b11; i_data = 36'h55;
    tick();
    i_clear = 1'b0; i_valid = 1'b0;
    chk("fl_valid", o_valid, 0);
    chk("fl_ctrl",  o_ctrl,  0);
    chk("fl_count", o_count, 0);
    chk("fl_data_kept", o_data, 36'h33);
    tick();
    chk("fl_no55_valid", o_valid, 0);
    chk("fl_no55_data", o_data, 36'h33);

    // reset mid-stream with two beats pushed
    i_ready = 1'b0; i_valid = 1'b1; i_ctrl = 2'b10; i_data = 36'h11;
    tick();
    i_data = 36'h12;
    tick();
    rst = 1'b1;
    tick();
    chk("mrst_valid", o_valid, 0);
    chk("mrst_ctrl",  o_ctrl,  0);
    chk("mrst_count", o_count, 0);
    chk("mrst_data",  o_data,  0);
    rst = 1'b0; i_valid = 1'b0;
    tick();
    chk("mrst_ready", o_ready, 1);
    chk("mrst_valid2", o_valid, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
